// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement reorder buffer with mispredict flush
//
// Purpose
//   Circular queue of in-flight instructions. The decoder allocates entries at
//   the tail, execution units complete them out of order by index, and the head
//   entry retires in order once it is ready. A retiring mispredicted branch
//   clears the whole buffer and publishes the redirect target.
//
// Configuration
//   ROB_WB_BYPASS_EN : when defined, operand queries also see a write-back that
//                      is presented in the same cycle (combinational bypass).
//
// Ports
//   clk_in, rst_in (sync, active-low), rdy_in (global enable, freezes state)
//   full                                  : buffer holds ROB_SIZE entries
//   issue_valid/issue_rd/issue_is_branch  : allocation request from decode
//   alloc_index                           : index the next issue receives
//   wb_valid/wb_index/wb_value/wb_mispredict : result write-back
//   query{1,2}_index -> query{1,2}_ready/_value : operand lookups
//   cdb_valid/cdb_index/cdb_value         : registered broadcast of a write-back
//   commit_valid/_rd/_value/_index        : registered retirement
//   flush/redirect_pc                     : registered pipeline clear + new PC

module reorder_buffer #(
    parameter int ROB_SIZE = 8,
    parameter int ROB_ADDR = 3
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    output logic                full,
    input  logic                issue_valid,
    input  logic [4:0]          issue_rd,
    input  logic                issue_is_branch,
    output logic [ROB_ADDR-1:0] alloc_index,
    input  logic                wb_valid,
    input  logic [ROB_ADDR-1:0] wb_index,
    input  logic [31:0]         wb_value,
    input  logic                wb_mispredict,
    input  logic [ROB_ADDR-1:0] query1_index,
    input  logic [ROB_ADDR-1:0] query2_index,
    output logic                query1_ready,
    output logic                query2_ready,
    output logic [31:0]         query1_value,
    output logic [31:0]         query2_value,
    output logic                cdb_valid,
    output logic [ROB_ADDR-1:0] cdb_index,
    output logic [31:0]         cdb_value,
    output logic                commit_valid,
    output logic [4:0]          commit_rd,
    output logic [31:0]         commit_value,
    output logic [ROB_ADDR-1:0] commit_index,
    output logic                flush,
    output logic [31:0]         redirect_pc
);

    localparam logic [ROB_ADDR:0]   LP_CNT_FULL = (ROB_ADDR+1)'(ROB_SIZE);
    localparam logic [ROB_ADDR:0]   LP_CNT_ONE  = (ROB_ADDR+1)'(1);
    localparam logic [ROB_ADDR-1:0] LP_PTR_ONE  = ROB_ADDR'(1);

    // Entry storage
    logic [ROB_SIZE-1:0] r_busy;
    logic [ROB_SIZE-1:0] r_ready;
    logic [ROB_SIZE-1:0] r_is_branch;
    logic [ROB_SIZE-1:0] r_mispredict;
    logic [4:0]          r_rd    [ROB_SIZE];
    logic [31:0]         r_value [ROB_SIZE];

    // Queue pointers
    logic [ROB_ADDR-1:0] r_head;
    logic [ROB_ADDR-1:0] r_tail;
    logic [ROB_ADDR:0]   r_count;

    // Registered outputs
    logic                r_cdb_valid;
    logic [ROB_ADDR-1:0] r_cdb_index;
    logic [31:0]         r_cdb_value;
    logic                r_commit_valid;
    logic [4:0]          r_commit_rd;
    logic [31:0]         r_commit_value;
    logic [ROB_ADDR-1:0] r_commit_index;
    logic                r_flush;
    logic [31:0]         r_redirect_pc;

    logic                w_full;
    logic                w_issue;
    logic                w_retire;
    logic                w_flush;
    logic                w_wb_accept;
    logic [ROB_ADDR:0]   w_count_next;
    logic                w_q1_ready;
    logic                w_q2_ready;
    logic [31:0]         w_q1_value;
    logic [31:0]         w_q2_value;

    // Full comes from the registered count only, so a retire in the same cycle
    // cannot make room for an issue.
    assign w_full      = (r_count == LP_CNT_FULL);
    assign w_issue     = issue_valid && !w_full;
    // Retire looks at the stored ready bit, so a write-back becomes retirable
    // one edge after it lands.
    assign w_retire    = r_busy[r_head] && r_ready[r_head];
    assign w_flush     = w_retire && r_is_branch[r_head] && r_mispredict[r_head];
    assign w_wb_accept = wb_valid && r_busy[wb_index];

    always_comb begin
        w_count_next = r_count;
        case ({w_issue, w_retire})
            2'b10:   w_count_next = r_count + LP_CNT_ONE;
            2'b01:   w_count_next = r_count - LP_CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    always_comb begin
        w_q1_ready = r_busy[query1_index] && r_ready[query1_index];
        w_q1_value = r_value[query1_index];
        w_q2_ready = r_busy[query2_index] && r_ready[query2_index];
        w_q2_value = r_value[query2_index];
`ifdef ROB_WB_BYPASS_EN
        // Forward a write-back that is only being sampled on this edge.
        if (wb_valid && (wb_index == query1_index) && r_busy[query1_index]) begin
            w_q1_ready = 1'b1;
            w_q1_value = wb_value;
        end
        if (wb_valid && (wb_index == query2_index) && r_busy[query2_index]) begin
            w_q2_ready = 1'b1;
            w_q2_value = wb_value;
        end
`endif
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_busy         <= '0;
            r_ready        <= '0;
            r_is_branch    <= '0;
            r_mispredict   <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                r_rd[i]    <= '0;
                r_value[i] <= '0;
            end
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_cdb_valid    <= 1'b0;
            r_cdb_index    <= '0;
            r_cdb_value    <= '0;
            r_commit_valid <= 1'b0;
            r_commit_rd    <= '0;
            r_commit_value <= '0;
            r_commit_index <= '0;
            r_flush        <= 1'b0;
            r_redirect_pc  <= '0;
        end else if (!rdy_in) begin
            // Frozen: only the one-cycle pulses drop.
            r_cdb_valid    <= 1'b0;
            r_commit_valid <= 1'b0;
            r_flush        <= 1'b0;
        end else begin
            r_commit_valid <= w_retire;
            if (w_retire) begin
                r_commit_rd    <= r_is_branch[r_head] ? 5'd0 : r_rd[r_head];
                r_commit_value <= r_value[r_head];
                r_commit_index <= r_head;
            end

            r_flush <= w_flush;
            if (w_flush) begin
                r_redirect_pc <= r_value[r_head];
            end

            if (w_flush) begin
                // Everything younger than the branch is wrong-path work,
                // including any issue or write-back arriving this cycle.
                r_busy       <= '0;
                r_ready      <= '0;
                r_is_branch  <= '0;
                r_mispredict <= '0;
                for (int i = 0; i < ROB_SIZE; i++) begin
                    r_rd[i]    <= '0;
                    r_value[i] <= '0;
                end
                r_head      <= '0;
                r_tail      <= '0;
                r_count     <= '0;
                r_cdb_valid <= 1'b0;
            end else begin
                r_cdb_valid <= w_wb_accept;
                if (w_wb_accept) begin
                    r_ready[wb_index]      <= 1'b1;
                    r_value[wb_index]      <= wb_value;
                    r_mispredict[wb_index] <= wb_mispredict;
                    r_cdb_index            <= wb_index;
                    r_cdb_value            <= wb_value;
                end

                if (w_retire) begin
                    r_busy[r_head] <= 1'b0;
                    r_head         <= r_head + LP_PTR_ONE;
                end

                // The tail slot is never busy when issue is allowed, so it
                // cannot collide with the write-back or retire slot above.
                if (w_issue) begin
                    r_busy[r_tail]       <= 1'b1;
                    r_ready[r_tail]      <= 1'b0;
                    r_is_branch[r_tail]  <= issue_is_branch;
                    r_mispredict[r_tail] <= 1'b0;
                    r_rd[r_tail]         <= issue_rd;
                    r_tail               <= r_tail + LP_PTR_ONE;
                end

                r_count <= w_count_next;
            end
        end
    end

    assign full         = w_full;
    assign alloc_index  = r_tail;
    assign query1_ready = w_q1_ready;
    assign query1_value = w_q1_value;
    assign query2_ready = w_q2_ready;
    assign query2_value = w_q2_value;
    assign cdb_valid    = r_cdb_valid;
    assign cdb_index    = r_cdb_index;
    assign cdb_value    = r_cdb_value;
    assign commit_valid = r_commit_valid;
    assign commit_rd    = r_commit_rd;
    assign commit_value = r_commit_value;
    assign commit_index = r_commit_index;
    assign flush        = r_flush;
    assign redirect_pc  = r_redirect_pc;

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - self-checking bench for reorder_buffer

module tb_reorder_buffer;

    localparam int SZ = 8;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in;
    logic        full;
    logic        issue_valid, issue_is_branch;
    logic [4:0]  issue_rd;
    logic [2:0]  alloc_index;
    logic        wb_valid, wb_mispredict;
    logic [2:0]  wb_index;
    logic [31:0] wb_value;
    logic [2:0]  query1_index, query2_index;
    logic        query1_ready, query2_ready;
    logic [31:0] query1_value, query2_value;
    logic        cdb_valid;
    logic [2:0]  cdb_index;
    logic [31:0] cdb_value;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [31:0] commit_value;
    logic [2:0]  commit_index;
    logic        flush;
    logic [31:0] redirect_pc;

    reorder_buffer #(.ROB_SIZE(8), .ROB_ADDR(3)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .full(full),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_is_branch(issue_is_branch),
        .alloc_index(alloc_index),
        .wb_valid(wb_valid), .wb_index(wb_index), .wb_value(wb_value), .wb_mispredict(wb_mispredict),
        .query1_index(query1_index), .query2_index(query2_index),
        .query1_ready(query1_ready), .query2_ready(query2_ready),
        .query1_value(query1_value), .query2_value(query2_value),
        .cdb_valid(cdb_valid), .cdb_index(cdb_index), .cdb_value(cdb_value),
        .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_value(commit_value),
        .commit_index(commit_index), .flush(flush), .redirect_pc(redirect_pc)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs;
        issue_valid = 0; issue_rd = 0; issue_is_branch = 0;
        wb_valid = 0; wb_index = 0; wb_value = 0; wb_mispredict = 0;
        query1_index = 0; query2_index = 0;
        rdy_in = 1;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst_in = 0;
        tick();
        tick();
        rst_in = 1;
    endtask

    task automatic do_issue(input logic [4:0] rd, input logic br);
        issue_valid = 1; issue_rd = rd; issue_is_branch = br;
        tick();
        issue_valid = 0; issue_is_branch = 0;
    endtask

    task automatic check_zero_state(input string tag);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_alloc"}, alloc_index, 0);
        chk({tag, "_cdbv"}, cdb_valid, 0);
        chk({tag, "_cdbi"}, cdb_index, 0);
        chk({tag, "_cdbval"}, cdb_value, 0);
        chk({tag, "_cv"}, commit_valid, 0);
        chk({tag, "_crd"}, commit_rd, 0);
        chk({tag, "_cval"}, commit_value, 0);
        chk({tag, "_cidx"}, commit_index, 0);
        chk({tag, "_flush"}, flush, 0);
        chk({tag, "_rpc"}, redirect_pc, 0);
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic        iv;
        logic [4:0]  rd;
        logic        wv;
        logic [2:0]  wi;
        logic [31:0] wval;
        logic        e_full;
        logic [2:0]  e_alloc;
        logic        e_cdbv;
        logic [2:0]  e_cdbi;
        logic [31:0] e_cdbval;
        logic        e_cv;
        logic [4:0]  e_crd;
        logic [31:0] e_cval;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic [4:0] rd, input logic wv,
                                input logic [2:0] wi, input logic [31:0] wval,
                                input logic e_full, input logic [2:0] e_alloc,
                                input logic e_cdbv, input logic [2:0] e_cdbi,
                                input logic [31:0] e_cdbval, input logic e_cv,
                                input logic [4:0] e_crd, input logic [31:0] e_cval);
        vec_t v;
        v.iv = iv; v.rd = rd; v.wv = wv; v.wi = wi; v.wval = wval;
        v.e_full = e_full; v.e_alloc = e_alloc; v.e_cdbv = e_cdbv; v.e_cdbi = e_cdbi;
        v.e_cdbval = e_cdbval; v.e_cv = e_cv; v.e_crd = e_crd; v.e_cval = e_cval;
        return v;
    endfunction

    vec_t tbl[15];

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0]  idx;
        logic [4:0]  rd;
        bit          br;
        bit          rdy;
        bit          mp;
        logic [31:0] val;
    } ent_t;

    ent_t        mq[$];
    logic [2:0]  m_tail;
    logic        m_cdbv, m_cv, m_fl;
    logic [2:0]  m_cdbi, m_ci;
    logic [31:0] m_cdbval, m_cval, m_rpc;
    logic [4:0]  m_crd;

    task automatic mquery(input logic [2:0] qi, output logic r, output logic [31:0] v);
        r = 0; v = 0;
        foreach (mq[k]) begin
            if (mq[k].idx == qi) begin
                r = mq[k].rdy; v = mq[k].val;
`ifdef ROB_WB_BYPASS_EN
                if (wb_valid && wb_index == qi) begin
                    r = 1; v = wb_value;
                end
`endif
            end
        end
    endtask

    task automatic model_step;
        bit   is_full, retire, fl;
        int   hit;
        is_full = (mq.size() == SZ);
        if (!rdy_in) begin
            m_cdbv = 0; m_cv = 0; m_fl = 0;
            return;
        end
        retire = (mq.size() > 0) && mq[0].rdy;
        fl     = retire && mq[0].br && mq[0].mp;
        hit    = -1;
        if (wb_valid) foreach (mq[k]) if (mq[k].idx == wb_index) hit = k;
        m_cv = retire;
        if (retire) begin
            m_crd = mq[0].br ? 5'd0 : mq[0].rd;
            m_cval = mq[0].val;
            m_ci = mq[0].idx;
        end
        m_fl = fl;
        if (fl) begin
            m_rpc = mq[0].val;
            mq.delete();
            m_tail = 0;
            m_cdbv = 0;
        end else begin
            m_cdbv = (hit >= 0);
            if (hit >= 0) begin
                mq[hit].rdy = 1; mq[hit].val = wb_value; mq[hit].mp = wb_mispredict;
                m_cdbi = wb_index; m_cdbval = wb_value;
            end
            if (retire) void'(mq.pop_front());
            if (issue_valid && !is_full) begin
                ent_t e;
                e.idx = m_tail; e.rd = issue_rd; e.br = issue_is_branch;
                e.rdy = 0; e.mp = 0; e.val = 0;
                mq.push_back(e);
                m_tail = m_tail + 3'd1;
            end
        end
    endtask

    initial begin
        logic        er;
        logic [31:0] ev;
        logic        exp_byp;

        rst_in = 0;
        idle_inputs();

        // ---------------- reset state ----------------
        do_reset();
        check_zero_state("reset");

        // ---------------- table: fill, full, wb->cdb->commit, full+retire ----------------
        for (int i = 0; i < 8; i++)
            tbl[i] = mk(1, 5'(i + 1), 0, 0, 0, 0, 3'(i), 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk(1, 9, 0, 0, 0,        1, 0, 0, 0, 0,        0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0,        1, 0, 0, 0, 0,        0, 0, 0);
        tbl[10] = mk(0, 0, 1, 0, 32'h1234, 1, 0, 1, 0, 32'h1234, 0, 0, 0);
        tbl[11] = mk(1, 9, 0, 0, 0,        1, 0, 0, 0, 0,        1, 1, 32'h1234);
        tbl[12] = mk(0, 0, 0, 0, 0,        0, 0, 0, 0, 0,        0, 0, 0);
        tbl[13] = mk(1, 9, 0, 0, 0,        0, 0, 0, 0, 0,        0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0,        1, 1, 0, 0, 0,        0, 0, 0);

        for (int i = 0; i < 15; i++) begin
            issue_valid = tbl[i].iv; issue_rd = tbl[i].rd; issue_is_branch = 0;
            wb_valid = tbl[i].wv; wb_index = tbl[i].wi; wb_value = tbl[i].wval; wb_mispredict = 0;
            #1;
            chk($sformatf("tbl%0d_full", i), full, tbl[i].e_full);
            chk($sformatf("tbl%0d_alloc", i), alloc_index, tbl[i].e_alloc);
            tick();
            chk($sformatf("tbl%0d_cdbv", i), cdb_valid, tbl[i].e_cdbv);
            if (tbl[i].e_cdbv) begin
                chk($sformatf("tbl%0d_cdbi", i), cdb_index, tbl[i].e_cdbi);
                chk($sformatf("tbl%0d_cdbval", i), cdb_value, tbl[i].e_cdbval);
            end
            chk($sformatf("tbl%0d_cv", i), commit_valid, tbl[i].e_cv);
            if (tbl[i].e_cv) begin
                chk($sformatf("tbl%0d_crd", i), commit_rd, tbl[i].e_crd);
                chk($sformatf("tbl%0d_cval", i), commit_value, tbl[i].e_cval);
            end
        end
        idle_inputs();

        // ---------------- out-of-order write-back, in-order commit ----------------
        do_reset();
        do_issue(1, 0); do_issue(2, 0); do_issue(3, 0);
        wb_valid = 1; wb_index = 2; wb_value = 32'h22; tick();
        chk("ooo_cdbi", cdb_index, 2);
        chk("ooo_cv0", commit_valid, 0);
        wb_index = 0; wb_value = 32'h20; tick();
        chk("ooo_cv1", commit_valid, 0);
        wb_index = 1; wb_value = 32'h21; tick();
        chk("ooo_c0v", commit_valid, 1);
        chk("ooo_c0i", commit_index, 0);
        chk("ooo_c0rd", commit_rd, 1);
        chk("ooo_c0val", commit_value, 32'h20);
        wb_valid = 0; tick();
        chk("ooo_c1v", commit_valid, 1);
        chk("ooo_c1i", commit_index, 1);
        chk("ooo_c1val", commit_value, 32'h21);
        tick();
        chk("ooo_c2v", commit_valid, 1);
        chk("ooo_c2i", commit_index, 2);
        chk("ooo_c2rd", commit_rd, 3);
        tick();
        chk("ooo_idle_cv", commit_valid, 0);
        chk("ooo_alloc", alloc_index, 3);

        // ---------------- mispredicted branch flush ----------------
        do_reset();
        do_issue(5, 0); do_issue(7, 1); do_issue(3, 0);
        wb_valid = 1; wb_index = 0; wb_value = 32'h11; wb_mispredict = 0; tick();
        wb_index = 1; wb_value = 32'h80; wb_mispredict = 1; tick();
        chk("br_c0v", commit_valid, 1);
        chk("br_c0rd", commit_rd, 5);
        chk("br_c0val", commit_value, 32'h11);
        chk("br_noflush", flush, 0);
        // issue and write-back collide with the flush edge
        issue_valid = 1; issue_rd = 9;
        wb_index = 2; wb_value = 32'h33; wb_mispredict = 0; tick();
        issue_valid = 0; wb_valid = 0;
        chk("br_flush", flush, 1);
        chk("br_rpc", redirect_pc, 32'h80);
        chk("br_cv", commit_valid, 1);
        chk("br_crd0", commit_rd, 0);
        chk("br_cidx", commit_index, 1);
        chk("br_cdbv", cdb_valid, 0);
        chk("br_alloc", alloc_index, 0);
        chk("br_full", full, 0);
        query1_index = 2; query2_index = 0; #1;
        chk("br_q1rdy", query1_ready, 0);
        chk("br_q2rdy", query2_ready, 0);
        tick();
        chk("br_flush_pulse", flush, 0);
        chk("br_cv_after", commit_valid, 0);
        do_issue(4, 0);
        chk("br_alloc1", alloc_index, 1);

        // ---------------- query bypass ----------------
        do_reset();
        do_issue(1, 0); do_issue(2, 0); do_issue(3, 0); do_issue(4, 0);
        wb_valid = 1; wb_index = 3; wb_value = 32'h55; query1_index = 3; query2_index = 2; #1;
`ifdef ROB_WB_BYPASS_EN
        exp_byp = 1;
`else
        exp_byp = 0;
`endif
        chk("byp_q1rdy", query1_ready, exp_byp);
        if (exp_byp) chk("byp_q1val", query1_value, 32'h55);
        chk("byp_q2rdy", query2_ready, 0);
        tick();
        wb_valid = 0; query2_index = 3; #1;
        chk("q_after_rdy", query1_ready, 1);
        chk("q_after_val", query1_value, 32'h55);
        chk("q2_after_val", query2_value, 32'h55);

        // ---------------- rdy_in freeze ----------------
        wb_valid = 1; wb_index = 0; wb_value = 32'h99; tick();
        chk("frz_cdbv_pre", cdb_valid, 1);
        rdy_in = 0; issue_valid = 1; issue_rd = 6; wb_index = 1; wb_value = 32'h77;
        tick();
        chk("frz_cdbv", cdb_valid, 0);
        chk("frz_cv", commit_valid, 0);
        chk("frz_alloc", alloc_index, 4);
        tick();
        chk("frz_cv2", commit_valid, 0);
        wb_valid = 0; query2_index = 1; #1;
        chk("frz_q2rdy", query2_ready, 0);
        rdy_in = 1; issue_valid = 0; tick();
        chk("thaw_cv", commit_valid, 1);
        chk("thaw_cidx", commit_index, 0);
        chk("thaw_cval", commit_value, 32'h99);
        chk("thaw_alloc", alloc_index, 4);

        // ---------------- reset mid-operation beats rdy_in ----------------
        rst_in = 0; rdy_in = 0; issue_valid = 1; query1_index = 3; tick();
        check_zero_state("midrst");
        chk("midrst_q1", query1_ready, 0);
        rst_in = 1;
        idle_inputs();

        // ---------------- randomized against model ----------------
        do_reset();
        mq.delete();
        m_tail = 0; m_cdbv = 0; m_cv = 0; m_fl = 0;
        m_cdbi = 0; m_ci = 0; m_cdbval = 0; m_cval = 0; m_rpc = 0; m_crd = 0;
        for (int c = 0; c < 3000; c++) begin
            rdy_in          = ($urandom_range(9) != 0);
            issue_valid     = $urandom_range(1);
            issue_rd        = 5'($urandom_range(31));
            issue_is_branch = ($urandom_range(3) == 0);
            wb_valid        = $urandom_range(1);
            if (mq.size() > 0 && $urandom_range(3) != 0)
                wb_index = mq[$urandom_range(mq.size() - 1)].idx;
            else
                wb_index = 3'($urandom_range(7));
            wb_value        = $urandom;
            wb_mispredict   = ($urandom_range(2) == 0);
            query1_index    = 3'($urandom_range(7));
            query2_index    = 3'($urandom_range(7));
            #1;
            chk("rnd_full", full, (mq.size() == SZ));
            chk("rnd_alloc", alloc_index, m_tail);
            mquery(query1_index, er, ev);
            chk("rnd_q1rdy", query1_ready, er);
            if (er) chk("rnd_q1val", query1_value, ev);
            mquery(query2_index, er, ev);
            chk("rnd_q2rdy", query2_ready, er);
            if (er) chk("rnd_q2val", query2_value, ev);
            model_step();
            tick();
            chk("rnd_cdbv", cdb_valid, m_cdbv);
            if (m_cdbv) begin
                chk("rnd_cdbi", cdb_index, m_cdbi);
                chk("rnd_cdbval", cdb_value, m_cdbval);
            end
            chk("rnd_cv", commit_valid, m_cv);
            if (m_cv) begin
                chk("rnd_crd", commit_rd, m_crd);
                chk("rnd_cval", commit_value, m_cval);
                chk("rnd_cidx", commit_index, m_ci);
            end
            chk("rnd_flush", flush, m_fl);
            if (m_fl) chk("rnd_rpc", redirect_pc, m_rpc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter ROB_SIZE, default 8, meaning entry count (power of two).
REQ-002 SHALL have parameter ROB_ADDR, default 3, meaning index width, log2(ROB_SIZE).
REQ-003 SHALL have port clk_in  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port rst_in  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port rdy_in  input  1  global enable; state frozen while low.
REQ-006 SHALL have port full  output  1  high when count == ROB_SIZE.
REQ-007 SHALL have port issue_valid  input  1  decoder allocates one entry.
REQ-008 SHALL have port issue_rd  input  5  destination register, 0 = none.
REQ-009 SHALL have port issue_is_branch  input  1  entry is a branch.
REQ-010 SHALL have port alloc_index  output  ROB_ADDR  index the next issue receives (= tail).
REQ-011 SHALL have port wb_valid  input  1  execution result returned.
REQ-012 SHALL have port wb_index  input  ROB_ADDR  entry being completed.
REQ-013 SHALL have port wb_value  input  32  result, or redirect target for branches.
REQ-014 SHALL have port wb_mispredict  input  1  branch mispredicted.
REQ-015 SHALL have ports query1_index/query2_index  input  ROB_ADDR  operand dependency lookups.
REQ-016 SHALL have ports query1_ready/query2_ready  output  1, query1_value/query2_value  output  32  combinational lookup results.
REQ-017 SHALL have ports cdb_valid  output  1, cdb_index  output  ROB_ADDR, cdb_value  output  32  broadcast to reservation stations.
REQ-018 SHALL have ports commit_valid  output  1, commit_rd  output  5, commit_value  output  32, commit_index  output  ROB_ADDR  retirement to register file.
REQ-019 SHALL have ports flush  output  1, redirect_pc  output  32  pipeline clear (drives RS_clear) and new PC.

Function
REQ-020 SHALL hold a circular queue: head, tail (ROB_ADDR bits, wrap modulo ROB_SIZE), count (ROB_ADDR+1 bits); entry = busy, ready, rd, value, is_branch, mispredict.
REQ-021 Issue SHALL be accepted only when issue_valid && !full; the entry at tail becomes busy, not ready, and tail increments.
REQ-022 full SHALL be computed from the registered count only; a same-cycle commit does not unblock issue.
REQ-023 Write-back SHALL set ready, value, mispredict of entry wb_index at the sampling edge; write-back to a non-busy entry SHALL be ignored.
REQ-024 cdb_valid/cdb_index/cdb_value SHALL be registered copies of an accepted write-back, one cycle later, asserted for exactly one cycle.
REQ-025 When the head entry is busy && ready, it SHALL retire on that edge: commit_* registered, commit_valid high one cycle, head increments, busy cleared; at most one retire per cycle.
REQ-026 An entry with ready set at edge E SHALL retire no earlier than edge E+1.
REQ-027 A retiring branch with mispredict set SHALL register flush=1, redirect_pc=value for one cycle, and on the same edge clear all entries, head=tail=count=0.
REQ-028 commit_rd SHALL be 0 for retiring branches.
REQ-029 queryN_ready/queryN_value SHALL reflect the stored entry (busy && ready, value).
REQ-030 Issue and retire in the same cycle SHALL leave count unchanged.
REQ-031 Flush SHALL override a same-cycle issue and write-back; no entry survives.
REQ-032 While rdy_in low, no state SHALL change and single-cycle outputs (cdb_valid, commit_valid, flush) SHALL deassert.

Reset
REQ-033 On rst_in low at a rising edge, all entries SHALL clear and head, tail, count SHALL be 0.
REQ-034 After reset full, cdb_valid, commit_valid, flush SHALL be 0; cdb_*, commit_*, redirect_pc SHALL be 0; alloc_index SHALL be 0.
REQ-035 Reset SHALL take priority over rdy_in and flush, including mid-operation.

Configuration
REQ-036 With macro ROB_WB_BYPASS_EN defined, queryN SHALL also return ready with wb_value when wb_valid && wb_index == queryN_index && entry busy, same cycle.
REQ-037 Without ROB_WB_BYPASS_EN, queries SHALL reflect stored state only (ready visible one cycle after write-back).

Verification
REQ-038 Reset, then issue 8 entries rd=1..8 -> alloc_index 0..7, full=1 after 8th, 9th issue ignored, tail stays 0.
REQ-039 Write-back index 0 value 0x1234 at edge E -> cdb_valid at E+1 with index 0/0x1234; commit_valid rd=1 value 0x1234 after edge E+1.
REQ-040 Write-back out of order (index 2 then 0, 1) -> commits strictly in order 0,1,2, one per cycle.
REQ-041 Branch at index 1, write-back mispredict=1 value 0x80 -> entry 0 commits, then flush=1 redirect_pc=0x80 for one cycle, count=0, alloc_index=0.
REQ-042 Full buffer, head ready, issue_valid same cycle -> head retires, issue rejected, count=7.
REQ-043 wb_valid index 3 value 0x55 with query1_index=3 same cycle -> query1_ready=1/0x55 with ROB_WB_BYPASS_EN, 0 without.
